mem_seq: RTL
============

Name: mem_seq

Overview:
- Initiator-side sequencer for the 8-bit CPU's 256x8 RAM.
- Owns the RAM's address, write-enable and write-data inputs. Consumes its combinational read data on the addr1 path and the addr2 path.
- Serves one CPU-side request at a time over a valid/ready handshake: FETCH (2-byte instruction), LOAD, STORE, or COPY (block move of up to 255 bytes, one byte per cycle).

Parameters:
- ADDR_W, 8, RAM address width; all address arithmetic wraps mod 2^ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  operation code: FETCH=0, LOAD=1, STORE=2, COPY=3.
- req_addr  in  ADDR_W  FETCH/LOAD/STORE address; COPY source.
- req_addr_b  in  ADDR_W  COPY destination; ignored for other ops.
- req_wdata  in  DATA_W  STORE data; COPY length (0..255).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data0  out  DATA_W  FETCH byte 0 / LOAD data; 0 otherwise.
- rsp_data1  out  DATA_W  FETCH byte 1; 0 otherwise.
- mem_addr1  out  ADDR_W  RAM read address, addr1 path.
- mem_addr2  out  ADDR_W  RAM read/write address, addr2 path.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata1  in  DATA_W  RAM read data at mem_addr1, combinational.
- mem_rdata3  in  DATA_W  RAM read data at mem_addr2, combinational.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state becomes IDLE.
  - rsp_valid=0, rsp_data0=0, rsp_data1=0.
  - Copy counter and latched operands cleared to 0.
- mem_we is gated combinationally by rst_n. No RAM write occurs at any edge where rst_n is low, including reset in the middle of a COPY. The bytes already written stay written.
- States: IDLE, ACCESS, COPY, RESP.
- IDLE:
  - req_ready=1; mem_we=0; mem_addr1, mem_addr2 and mem_wdata are 0.
  - On req_valid, latch op, addr, addr_b and wdata.
  - Next state is COPY if op=COPY and wdata!=0; otherwise ACCESS.
- req_ready is 0 in every state other than IDLE. req_* is sampled only at the accept edge.
- ACCESS lasts exactly one cycle and drives the RAM from latched values:
  - FETCH: mem_addr1=addr, mem_addr2=addr+1 mod 256. Latch rsp_data0=mem_rdata1 and rsp_data1=mem_rdata3, so address 0xFF wraps to 0x00.
  - LOAD: mem_addr2=addr. Latch rsp_data0=mem_rdata3 and rsp_data1=0.
  - STORE: mem_addr2=addr, mem_wdata=wdata, mem_we=1. The RAM commits at the edge ending ACCESS. Response data is 0.
  - COPY with length 0: no RAM activity; response data is 0.
  - Next state: RESP.
- COPY, with counter i running 0..len-1:
  - mem_addr1=src+i, mem_addr2=dst+i, both mod 256.
  - mem_wdata=mem_rdata1, mem_we=1.
  - Next state is RESP when i=len-1; otherwise i increments.
  - A byte written in cycle k is visible to the read in cycle k+1. Overlapping regions therefore get forward-copy semantics: dst=src+1 replicates mem[src].
  - Both address streams wrap independently past 0xFF.
- RESP: rsp_valid=1 for exactly one cycle, rsp_data* hold the latched values, mem_we=0. Next state: IDLE.
- Latency from the accept edge to rsp_valid:
  - 2 cycles for FETCH, LOAD, STORE and COPY with length 0.
  - len+1 cycles for COPY.
- Minimum spacing between accepts is 3 cycles.
- rsp_data* return to 0 at the next accept.
- A LOAD issued right after a STORE to the same address returns the new data, because the store commits before the LOAD's ACCESS cycle.
- All arithmetic is unsigned and truncated to ADDR_W.

Decomposition:
- mem_seq_pkg holds:
  - op_e enum (FETCH, LOAD, STORE, COPY).
  - state_e enum (IDLE, ACCESS, COPY, RESP).
  - ADDR_W and DATA_W defaults.
- No sub-module. The bench instantiates the existing RAM beside mem_seq, with mem_addr1/mem_addr2 wired to the RAM's addr1/addr2 and mem_rdata1/mem_rdata3 wired to its out1/out3.

Test Plan:
- STORE addr=0x10 data=0xA5, then LOAD 0x10 → rsp_valid 2 cycles after each accept; LOAD rsp_data0=0xA5, rsp_data1=0; mem_we high exactly 1 cycle.
- Preload mem[0xFF]=0x3C and mem[0x00]=0x7E; FETCH 0xFF → rsp_data0=0x3C, rsp_data1=0x7E.
- Preload mem[0x20..0x23]=01,02,03,04; COPY src=0x20 dst=0x80 len=4 → mem[0x80..0x83]=01..04; mem_we high 4 consecutive cycles; rsp_valid 5 cycles after accept; req_ready=0 throughout.
- Preload mem[0x40]=0x55; COPY src=0x40 dst=0x41 len=3 → mem[0x41..0x43]=0x55. Also COPY src=0xFE dst=0x10 len=3 → mem[0x10..0x12] equals the original mem[0xFE], mem[0xFF], mem[0x00].
- COPY len=0 → rsp_valid 2 cycles after accept, mem_we never asserted.
- COPY len=8 with rst_n low on its 4th COPY cycle → exactly 3 bytes written, no write at the reset edge; after reset release: req_ready=1, rsp_valid=0, rsp_data0/1=0, and a following LOAD works normally.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and default widths for the RAM-side memory sequencer.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_COPY  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_COPY   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_seq.sv
// Sequences CPU FETCH/LOAD/STORE/COPY requests onto a 256x8 RAM with combinational reads.
// Latency: accept edge to rsp_valid is 2 cycles, or len+1 cycles for a non-empty COPY.
// Backpressure: req_ready is high only in IDLE; one request in flight, no response stall.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata1,
    input  logic [DATA_W-1:0] mem_rdata3
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cnt;
    logic              last_copy;
    logic              we_raw;

    // wdata_q holds the COPY length; the final byte is at cnt == len-1
    assign last_copy = (cnt == (wdata_q - DATA_W'(1)));
    assign req_ready = (state == ST_IDLE);

    // Reset gates the write strobe so an in-flight COPY never writes at a reset edge
    assign mem_we = we_raw & rst_n;

    // Request FSM: latch operands at accept, capture read data, emit one-cycle response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_FETCH;
            addr_q    <= '0;
            addr_b_q  <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data0 <= '0;
            rsp_data1 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_e'(req_op);
                        addr_q    <= req_addr;
                        addr_b_q  <= req_addr_b;
                        wdata_q   <= req_wdata;
                        cnt       <= '0;
                        rsp_data0 <= '0;
                        rsp_data1 <= '0;
                        if (op_e'(req_op) == OP_COPY && req_wdata != '0) begin
                            state <= ST_COPY;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    case (op_q)
                        OP_FETCH: begin
                            rsp_data0 <= mem_rdata1;
                            rsp_data1 <= mem_rdata3;
                        end
                        OP_LOAD: begin
                            rsp_data0 <= mem_rdata3;
                            rsp_data1 <= '0;
                        end
                        default: begin
                            rsp_data0 <= '0;
                            rsp_data1 <= '0;
                        end
                    endcase
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_COPY: begin
                    if (last_copy) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt + DATA_W'(1);
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM drive: addresses/data from latched operands; COPY forwards read data straight to write
    always_comb begin
        mem_addr1 = '0;
        mem_addr2 = '0;
        mem_wdata = '0;
        we_raw    = 1'b0;
        case (state)
            ST_ACCESS: begin
                case (op_q)
                    OP_FETCH: begin
                        mem_addr1 = addr_q;
                        mem_addr2 = addr_q + ADDR_W'(1);
                    end
                    OP_LOAD: begin
                        mem_addr2 = addr_q;
                    end
                    OP_STORE: begin
                        mem_addr2 = addr_q;
                        mem_wdata = wdata_q;
                        we_raw    = 1'b1;
                    end
                    default: begin
                        mem_addr1 = '0;
                    end
                endcase
            end
            ST_COPY: begin
                mem_addr1 = addr_q + ADDR_W'(cnt);
                mem_addr2 = addr_b_q + ADDR_W'(cnt);
                mem_wdata = mem_rdata1;
                we_raw    = 1'b1;
            end
            default: begin
                we_raw = 1'b0;
            end
        endcase
    end

endmodule
